// File: rtl/plane_lane_ctrl_pkg.sv
// plane_lane_ctrl_pkg: move codes, FSM state encoding and width helper shared by the plane lane controller
package plane_lane_ctrl_pkg;
  typedef enum logic [1:0] {MOVE_DOWN = 2'd0, MOVE_UP = 2'd1, MOVE_NONE = 2'd2, MOVE_RSVD = 2'd3} move_t;
  typedef enum logic [1:0] {IDLE = 2'd0, GLIDE = 2'd1, FREEZE = 2'd2} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/plane_lane_ctrl_if.sv
// plane_lane_ctrl_if: key-control/renderer side bundle of the plane lane controller
//   move/enable/crash : commands from key control (master -> slave)
//   plane_y/lane/busy/q_full/q_drop : plane position and queue status (slave -> master)
interface plane_lane_ctrl_if
  import plane_lane_ctrl_pkg::*;
#(
  parameter int LANES = 4,
  parameter int Y_W   = 10
);
  localparam int L_W = clog2(LANES);
  logic [1:0]     move;
  logic           enable;
  logic           crash;
  logic [Y_W-1:0] plane_y;
  logic [L_W-1:0] lane;
  logic           busy;
  logic           q_full;
  logic           q_drop;
  modport master(output move, enable, crash, input plane_y, lane, busy, q_full, q_drop);
  modport slave(input move, enable, crash, output plane_y, lane, busy, q_full, q_drop);
endinterface

// File: rtl/plane_lane_ctrl_move_fifo.sv
// move_fifo: synchronous FIFO of 1-bit direction entries with flush
//   clk, rst_n : clock, async active-low reset
//   push/din   : write request and direction bit (1 = up)
//   pop/dout   : read request and head entry
//   flush      : empty the queue (wins over push/pop)
//   full/empty : occupancy flags
module move_fifo
  import plane_lane_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
)(
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);
  localparam int P_W = clog2(DEPTH);
  localparam logic [P_W:0] N = (P_W + 1)'(DEPTH);
  logic [DEPTH-1:0] mem;
  logic [P_W-1:0]   wr, rd;
  logic [P_W:0]     cnt;
  logic             do_push, do_pop;
  always_comb begin
    full = cnt == N;
    empty = cnt == '0;
    do_pop = pop && !empty;
    // a full queue still accepts when the head leaves in the same cycle
    do_push = push && (!full || do_pop);
    dout = mem[rd];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem <= '0;
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      if (do_push) begin
        mem[wr] <= din;
        wr <= wr + 1'b1;
      end
      if (do_pop) rd <= rd + 1'b1;
      cnt <= cnt + {{P_W{1'b0}}, do_push} - {{P_W{1'b0}}, do_pop};
    end
endmodule

// File: rtl/plane_lane_ctrl.sv
// plane_lane_ctrl: queues lane-change commands and glides the plane one pixel per STEP_DIV cycles
//   clk, rst_n : clock, async active-low reset
//   bus.move/enable/crash : move code, run/pause, collision freeze
//   bus.plane_y/lane/busy : plane top y, rest lane, glide in progress
//   bus.q_full/q_drop     : queue full, 1-cycle discarded-command pulse
module plane_lane_ctrl
  import plane_lane_ctrl_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int LANE_H     = 32,
  parameter int Y_W        = 10,
  parameter int STEP_DIV   = 250000,
  parameter int QDEPTH     = 4,
  parameter int START_LANE = 1
)(
  input logic clk,
  input logic rst_n,
  plane_lane_ctrl_if.slave bus
);
  localparam int L_W = clog2(LANES);
  localparam int T_W = clog2(STEP_DIV);
  localparam logic [L_W-1:0] START_L  = L_W'(START_LANE);
  localparam logic [L_W-1:0] LAST_L   = L_W'(LANES - 1);
  localparam logic [Y_W-1:0] START_Y  = Y_W'(START_LANE * LANE_H);
  localparam logic [T_W-1:0] TICK_MAX = T_W'(STEP_DIV - 1);
  if ((LANES - 1) * LANE_H >= (1 << Y_W)) begin : g_y_fit
    $error("plane_lane_ctrl: (LANES-1)*LANE_H does not fit in Y_W bits");
  end
  if (STEP_DIV < 2) begin : g_div_min
    $error("plane_lane_ctrl: STEP_DIV must be at least 2");
  end
  state_t         state;
  logic [L_W-1:0] lane_r, tgt;
  logic [T_W-1:0] tick;
  logic [Y_W-1:0] y, y_nxt, tgt_y;
  logic           dir, busy_r, drop_r;
  logic           mv, accept, pop, flush, blocked;
  logic           q_dout, q_full, q_empty;
  always_comb begin
    mv = bus.move == MOVE_DOWN || bus.move == MOVE_UP;
    accept = mv && bus.enable && !bus.crash && state != FREEZE;
    pop = state == IDLE && !q_empty && bus.enable && !bus.crash;
    flush = bus.crash || state == FREEZE;
    // popped command would leave the lane range: consumed without moving
    blocked = q_dout ? lane_r == '0 : lane_r == LAST_L;
    y_nxt = dir ? y - 1'b1 : y + 1'b1;
    tgt_y = Y_W'(tgt * LANE_H);
  end
  move_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (pop),
    .flush (flush),
    .din   (bus.move[0]),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      lane_r <= START_L;
      tgt <= START_L;
      dir <= 1'b0;
      tick <= '0;
      y <= START_Y;
      busy_r <= 1'b0;
      drop_r <= 1'b0;
    end else begin
      drop_r <= mv && (bus.crash || (accept && q_full && !pop));
      if (bus.crash) begin
        state <= FREEZE;
        busy_r <= 1'b0;
      end else case (state)
        IDLE: if (pop && !blocked) begin
          tgt <= q_dout ? lane_r - 1'b1 : lane_r + 1'b1;
          dir <= q_dout;
          tick <= '0;
          busy_r <= 1'b1;
          state <= GLIDE;
        end
        GLIDE: if (bus.enable) begin
          tick <= tick == TICK_MAX ? '0 : tick + 1'b1;
          if (tick == TICK_MAX) begin
            y <= y_nxt;
            if (y_nxt == tgt_y) begin
              lane_r <= tgt;
              busy_r <= 1'b0;
              state <= IDLE;
            end
          end
        end
        FREEZE: if (!bus.enable) begin
          lane_r <= START_L;
          y <= START_Y;
          tick <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  assign bus.plane_y = y;
  assign bus.lane = lane_r;
  assign bus.busy = busy_r;
  assign bus.q_full = q_full;
  assign bus.q_drop = drop_r;
endmodule

// File: tb/tb_plane_lane_ctrl.sv
// tb_plane_lane_ctrl: scenario bench with a lane scoreboard for plane_lane_ctrl
module tb_plane_lane_ctrl;
  import plane_lane_ctrl_pkg::*;
  localparam int LANES = 4, LANE_H = 8, Y_W = 10, STEP_DIV = 4, QDEPTH = 4, START_LANE = 1;
  localparam int L_W = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int m_lane = START_LANE;
  always #5 clk = ~clk;
  plane_lane_ctrl_if #(.LANES(LANES), .Y_W(Y_W)) bus ();
  plane_lane_ctrl #(
    .LANES(LANES), .LANE_H(LANE_H), .Y_W(Y_W), .STEP_DIV(STEP_DIV), .QDEPTH(QDEPTH), .START_LANE(START_LANE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  // drive one move for one cycle; the model predicts the lane each accepted command ends at
  task automatic issue(input logic [1:0] m);
    bus.move = m;
    if (bus.enable && !bus.crash) begin
      if (m == MOVE_UP && m_lane > 0) begin
        m_lane--;
        exp_q.push_back(m_lane);
      end else if (m == MOVE_DOWN && m_lane < LANES - 1) begin
        m_lane++;
        exp_q.push_back(m_lane);
      end
    end
    @(negedge clk);
    bus.move = MOVE_NONE;
  endtask
  // wait for a glide to start and finish; hands back the expected end lane from the scoreboard
  task automatic glide_end(output bit ok, output int e);
    int k;
    bit started;
    k = 0;
    while (!bus.busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    started = bus.busy;
    while (bus.busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    ok = started && !bus.busy;
    e = -1;
    if (exp_q.size() > 0) e = exp_q.pop_front();
  endtask
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus.plane_y, bus.lane, bus.busy, bus.q_full, bus.q_drop} !== {10'd8, 2'd1, 3'b000}) begin
      failures++;
      $display("FAIL reset_init got y=%0d lane=%0d busy=%b full=%b drop=%b exp y=8 lane=1 busy=0 full=0 drop=0",
               bus.plane_y, bus.lane, bus.busy, bus.q_full, bus.q_drop);
    end
    rst_n = 1'b1;
    bus.enable = 1'b1;
    issue(MOVE_DOWN);
    issue(MOVE_DOWN);
    issue(MOVE_DOWN);
    repeat (6) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_glide got busy=%b exp busy=1", bus.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.plane_y, bus.lane, bus.busy, bus.q_full, bus.q_drop} !== {10'd8, 2'd1, 3'b000}) begin
      failures++;
      $display("FAIL reset_async got y=%0d lane=%0d busy=%b full=%b drop=%b exp y=8 lane=1 busy=0 full=0 drop=0",
               bus.plane_y, bus.lane, bus.busy, bus.q_full, bus.q_drop);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    m_lane = START_LANE;
    repeat (20) @(negedge clk);
    checks++;
    if ({bus.busy, bus.lane, bus.plane_y} !== {1'b0, 2'd1, 10'd8}) begin
      failures++;
      $display("FAIL reset_queue_empty got busy=%b lane=%0d y=%0d exp busy=0 lane=1 y=8", bus.busy, bus.lane, bus.plane_y);
    end
  endtask
  task automatic test_single_down();
    int e;
    issue(MOVE_DOWN);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL sd_queued got busy=%b exp busy=0", bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL sd_busy_start got busy=%b exp busy=1", bus.busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.plane_y !== 10'd8) begin
      failures++;
      $display("FAIL sd_y_hold got y=%0d exp y=8", bus.plane_y);
    end
    @(negedge clk);
    checks++;
    if (bus.plane_y !== 10'd9) begin
      failures++;
      $display("FAIL sd_y_step1 got y=%0d exp y=9", bus.plane_y);
    end
    repeat (27) @(negedge clk);
    checks++;
    if ({bus.busy, bus.plane_y} !== {1'b1, 10'd15}) begin
      failures++;
      $display("FAIL sd_y_step7 got busy=%b y=%0d exp busy=1 y=15", bus.busy, bus.plane_y);
    end
    @(negedge clk);
    e = -1;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    checks++;
    if (e < 0 || bus.busy !== 1'b0 || bus.lane !== L_W'(e) || bus.plane_y !== Y_W'(e * LANE_H)) begin
      failures++;
      $display("FAIL sd_done got busy=%b lane=%0d y=%0d exp busy=0 lane=%0d y=%0d", bus.busy, bus.lane, bus.plane_y, e, e * LANE_H);
    end
  endtask
  task automatic test_boundary();
    bit ok;
    int e;
    issue(MOVE_UP);
    glide_end(ok, e);
    checks++;
    if (!ok || e < 0 || bus.lane !== L_W'(e) || bus.plane_y !== Y_W'(e * LANE_H)) begin
      failures++;
      $display("FAIL bd_to_lane1 got ok=%0d lane=%0d y=%0d exp lane=%0d y=%0d", ok, bus.lane, bus.plane_y, e, e * LANE_H);
    end
    issue(MOVE_UP);
    issue(MOVE_UP);
    glide_end(ok, e);
    checks++;
    if (!ok || e < 0 || bus.lane !== L_W'(e) || bus.plane_y !== Y_W'(e * LANE_H)) begin
      failures++;
      $display("FAIL bd_to_lane0 got ok=%0d lane=%0d y=%0d exp lane=%0d y=%0d", ok, bus.lane, bus.plane_y, e, e * LANE_H);
    end
    repeat (10) @(negedge clk);
    checks++;
    if ({bus.busy, bus.lane, bus.plane_y} !== {1'b0, 2'd0, 10'd0}) begin
      failures++;
      $display("FAIL bd_discard got busy=%b lane=%0d y=%0d exp busy=0 lane=0 y=0", bus.busy, bus.lane, bus.plane_y);
    end
  endtask
  task automatic test_overflow();
    bit ok;
    int e;
    issue(MOVE_DOWN);
    glide_end(ok, e);
    checks++;
    if (!ok || e < 0 || bus.lane !== L_W'(e) || bus.plane_y !== Y_W'(e * LANE_H)) begin
      failures++;
      $display("FAIL ov_pre got ok=%0d lane=%0d y=%0d exp lane=%0d y=%0d", ok, bus.lane, bus.plane_y, e, e * LANE_H);
    end
    repeat (5) issue(MOVE_DOWN);
    checks++;
    if ({bus.q_full, bus.q_drop} !== 2'b10) begin
      failures++;
      $display("FAIL ov_full got full=%b drop=%b exp full=1 drop=0", bus.q_full, bus.q_drop);
    end
    issue(MOVE_DOWN);
    checks++;
    if (bus.q_drop !== 1'b1) begin
      failures++;
      $display("FAIL ov_drop got drop=%b exp drop=1", bus.q_drop);
    end
    @(negedge clk);
    checks++;
    if (bus.q_drop !== 1'b0) begin
      failures++;
      $display("FAIL ov_drop_pulse got drop=%b exp drop=0", bus.q_drop);
    end
    for (int i = 0; i < 2; i++) begin
      glide_end(ok, e);
      checks++;
      if (!ok || e < 0 || bus.lane !== L_W'(e) || bus.plane_y !== Y_W'(e * LANE_H)) begin
        failures++;
        $display("FAIL ov_glide%0d got ok=%0d lane=%0d y=%0d exp lane=%0d y=%0d", i, ok, bus.lane, bus.plane_y, e, e * LANE_H);
      end
    end
    repeat (20) @(negedge clk);
    checks++;
    if ({bus.busy, bus.lane, bus.plane_y, bus.q_full} !== {1'b0, 2'd3, 10'd24, 1'b0}) begin
      failures++;
      $display("FAIL ov_boundary got busy=%b lane=%0d y=%0d full=%b exp busy=0 lane=3 y=24 full=0",
               bus.busy, bus.lane, bus.plane_y, bus.q_full);
    end
  endtask
  task automatic test_pause();
    int e;
    int k;
    logic [Y_W-1:0] y0;
    issue(MOVE_UP);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL pa_start got busy=%b exp busy=1", bus.busy);
    end
    repeat (10) @(negedge clk);
    y0 = bus.plane_y;
    bus.enable = 1'b0;
    repeat (10) @(negedge clk);
    issue(MOVE_DOWN);
    repeat (9) @(negedge clk);
    checks++;
    if ({bus.busy, bus.plane_y} !== {1'b1, y0}) begin
      failures++;
      $display("FAIL pa_hold got busy=%b y=%0d exp busy=1 y=%0d", bus.busy, bus.plane_y, y0);
    end
    bus.enable = 1'b1;
    k = 0;
    while (bus.busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    e = -1;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    checks++;
    if (k != 22 || e < 0 || bus.lane !== L_W'(e) || bus.plane_y !== Y_W'(e * LANE_H)) begin
      failures++;
      $display("FAIL pa_resume got cycles=%0d lane=%0d y=%0d exp cycles=22 lane=%0d y=%0d", k, bus.lane, bus.plane_y, e, e * LANE_H);
    end
    repeat (10) @(negedge clk);
    checks++;
    if ({bus.busy, bus.lane} !== {1'b0, 2'd2}) begin
      failures++;
      $display("FAIL pa_no_accept got busy=%b lane=%0d exp busy=0 lane=2", bus.busy, bus.lane);
    end
  endtask
  task automatic test_crash();
    bit ok;
    int e;
    logic [Y_W-1:0] y0;
    issue(MOVE_DOWN);
    issue(MOVE_UP);
    issue(MOVE_UP);
    repeat (5) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL cr_pre got busy=%b exp busy=1", bus.busy);
    end
    y0 = bus.plane_y;
    bus.crash = 1'b1;
    issue(MOVE_DOWN);
    checks++;
    if ({bus.busy, bus.q_drop, bus.q_full, bus.plane_y} !== {1'b0, 1'b1, 1'b0, y0}) begin
      failures++;
      $display("FAIL cr_freeze got busy=%b drop=%b full=%b y=%0d exp busy=0 drop=1 full=0 y=%0d",
               bus.busy, bus.q_drop, bus.q_full, bus.plane_y, y0);
    end
    repeat (5) @(negedge clk);
    bus.crash = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.lane, bus.plane_y} !== {1'b0, 2'd2, y0}) begin
      failures++;
      $display("FAIL cr_hold got busy=%b lane=%0d y=%0d exp busy=0 lane=2 y=%0d", bus.busy, bus.lane, bus.plane_y, y0);
    end
    bus.enable = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.lane, bus.plane_y} !== {1'b0, 2'd1, 10'd8}) begin
      failures++;
      $display("FAIL cr_exit got busy=%b lane=%0d y=%0d exp busy=0 lane=1 y=8", bus.busy, bus.lane, bus.plane_y);
    end
    bus.enable = 1'b1;
    exp_q.delete();
    m_lane = START_LANE;
    repeat (40) @(negedge clk);
    checks++;
    if ({bus.busy, bus.lane, bus.plane_y} !== {1'b0, 2'd1, 10'd8}) begin
      failures++;
      $display("FAIL cr_flushed got busy=%b lane=%0d y=%0d exp busy=0 lane=1 y=8", bus.busy, bus.lane, bus.plane_y);
    end
    issue(MOVE_DOWN);
    glide_end(ok, e);
    checks++;
    if (!ok || e < 0 || bus.lane !== L_W'(e) || bus.plane_y !== Y_W'(e * LANE_H)) begin
      failures++;
      $display("FAIL cr_resume got ok=%0d lane=%0d y=%0d exp lane=%0d y=%0d", ok, bus.lane, bus.plane_y, e, e * LANE_H);
    end
  endtask
  initial begin
    bus.move = MOVE_NONE;
    bus.enable = 1'b0;
    bus.crash = 1'b0;
    test_reset();
    test_single_down();
    test_boundary();
    test_overflow();
    test_pause();
    test_crash();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got pending=%0d exp pending=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
